// File: rtl/mac_seq_ctrl.sv
// Sequencer for one row of cascaded MAC columns: streams key then query vectors
// from the activation SRAM into column 0 and counts psum writes from the last column.
module mac_seq_ctrl #(
  parameter int col      = 8,
  parameter int load_cyc = col + 2,
  parameter int addr_bw  = 7,
  parameter int key_base = 0,
  parameter int q_base   = 16,
  parameter int nq_bw    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [nq_bw-1:0]   num_q,
  input  logic               ofifo_full,
  input  logic               col_wr,
  output logic               mem_cen,
  output logic [addr_bw-1:0] mem_addr,
  output logic [1:0]         inst,
  output logic               busy,
  output logic               done
);

  localparam int KC_BW = $clog2(load_cyc + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic               rd_p0, rd_nx;
  logic [addr_bw-1:0] addr_p0, addr_nx;
  logic [1:0]         inst_p1;
  logic [KC_BW-1:0]   kcnt, kcnt_nx;
  logic [nq_bw-1:0]   qcnt, qcnt_nx;
  logic [nq_bw-1:0]   nq, nq_nx;
  logic [nq_bw:0]     wcnt, wcnt_nx;

  // Address sums wrap modulo 2^addr_bw by truncation.
  function automatic logic [addr_bw-1:0] addr_at(input int base, input int ofs);
    logic [31:0] s;
    s = base + ofs;
    return s[addr_bw-1:0];
  endfunction

  function automatic logic [nq_bw:0] sat_inc(input logic [nq_bw:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  always_comb begin
    state_nx = state;
    rd_nx    = 1'b0;
    addr_nx  = addr_p0;
    kcnt_nx  = kcnt;
    qcnt_nx  = qcnt;
    nq_nx    = nq;
    wcnt_nx  = sat_inc(wcnt, col_wr && (state != S_IDLE));
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_LOAD;
          rd_nx    = 1'b1;
          addr_nx  = addr_at(key_base, 0);
          kcnt_nx  = '0;
          qcnt_nx  = '0;
          nq_nx    = num_q;
          wcnt_nx  = '0;
        end
      end
      S_LOAD: begin
        if (kcnt == KC_BW'(load_cyc - 1)) begin
          state_nx = S_GAP;
        end else begin
          rd_nx   = 1'b1;
          kcnt_nx = kcnt + 1'b1;
          addr_nx = addr_at(key_base, int'(kcnt) + 1);
        end
      end
      // qcnt counts query reads already issued; a full FIFO holds address and count.
      S_GAP, S_EXEC: begin
        if (qcnt == nq) begin
          state_nx = S_DRAIN;
        end else begin
          state_nx = S_EXEC;
          if (!ofifo_full) begin
            rd_nx   = 1'b1;
            addr_nx = addr_at(q_base, int'(qcnt));
            qcnt_nx = qcnt + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (wcnt == {1'b0, nq}) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // p0: read issued this cycle; p1: its instruction, aligned with SRAM data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      rd_p0   <= 1'b0;
      addr_p0 <= '0;
      inst_p1 <= 2'b00;
      kcnt    <= '0;
      qcnt    <= '0;
      wcnt    <= '0;
    end else begin
      state   <= state_nx;
      rd_p0   <= rd_nx;
      addr_p0 <= addr_nx;
      inst_p1 <= rd_p0 ? ((state == S_EXEC) ? 2'b10 : 2'b01) : 2'b00;
      kcnt    <= kcnt_nx;
      qcnt    <= qcnt_nx;
      wcnt    <= wcnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    nq <= nq_nx;
  end

  assign mem_cen  = ~rd_p0;
  assign mem_addr = addr_p0;
  assign inst     = inst_p1;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: basic run, zero queries, backpressure,
// start collisions, reset mid-EXEC and query-address wrap.
module tb_mac_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, ofifo_full, col_wr;
  logic [5:0] num_q;
  logic       mem_cen, w_mem_cen, busy, w_busy, done, w_done;
  logic [6:0] mem_addr, w_mem_addr;
  logic [1:0] inst, w_inst;

  always #5 clk = ~clk;

  mac_seq_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .num_q(num_q),
    .ofifo_full(ofifo_full), .col_wr(col_wr),
    .mem_cen(mem_cen), .mem_addr(mem_addr), .inst(inst),
    .busy(busy), .done(done)
  );

  mac_seq_ctrl #(.q_base(126)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .num_q(num_q),
    .ofifo_full(ofifo_full), .col_wr(col_wr),
    .mem_cen(w_mem_cen), .mem_addr(w_mem_addr), .inst(w_inst),
    .busy(w_busy), .done(w_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  logic       sel_wrap = 1'b0;
  logic       c_cen, c_busy, c_done;
  logic [6:0] c_addr;
  logic [1:0] c_inst;
  assign c_cen  = sel_wrap ? w_mem_cen  : mem_cen;
  assign c_addr = sel_wrap ? w_mem_addr : mem_addr;
  assign c_inst = sel_wrap ? w_inst     : inst;
  assign c_busy = sel_wrap ? w_busy     : busy;
  assign c_done = sel_wrap ? w_done     : done;

  // Array model: a query instruction emerges as col_wr seven cycles later.
  logic       wr_mode = 1'b0, man_wr = 1'b0, model_wr = 1'b0;
  logic [7:0] wr_pipe = '0;
  assign col_wr = wr_mode ? man_wr : model_wr;

  logic       rec = 1'b0;
  int         ridx = 0;
  logic       t_cen [512];
  logic [6:0] t_addr[512];
  logic [1:0] t_inst[512];
  logic       t_busy[512];
  logic       t_done[512];

  always @(posedge clk) begin
    #1;
    if (rec && ridx < 512) begin
      t_cen[ridx]  = c_cen;
      t_addr[ridx] = c_addr;
      t_inst[ridx] = c_inst;
      t_busy[ridx] = c_busy;
      t_done[ridx] = c_done;
      ridx++;
    end
    wr_pipe  = {wr_pipe[6:0], (c_inst == 2'b10)};
    model_wr = wr_pipe[7];
  end

  int         n_rd, n_q10, bubbles, done_cnt, done_idx;
  logic [6:0] rd_addr[64];

  task automatic analyze();
    int first10, last10;
    n_rd = 0; n_q10 = 0; bubbles = 0; done_cnt = 0; done_idx = -1;
    first10 = -1; last10 = -1;
    for (int i = 0; i < ridx; i++) begin
      if (!t_cen[i]) begin
        if (n_rd < 64) rd_addr[n_rd] = t_addr[i];
        n_rd++;
      end
      if (t_inst[i] == 2'b10) begin
        n_q10++;
        if (first10 < 0) first10 = i;
        last10 = i;
      end
      if (t_done[i]) begin
        done_cnt++;
        done_idx = i;
      end
    end
    if (first10 >= 0)
      for (int i = first10; i <= last10; i++)
        if (t_inst[i] == 2'b00) bubbles++;
  endtask

  task automatic check_addrs(input string tag, input int from, input int cnt, input int base);
    int errs;
    logic [6:0] e;
    errs = 0;
    for (int i = 0; i < cnt; i++) begin
      e = 7'(base + i);
      if (from + i >= 64 || rd_addr[from + i] !== e) errs++;
    end
    check(tag, errs, 0);
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 0 of the run.
  task automatic do_start(input int n);
    start = 1'b1;
    num_q = 6'(n);
    @(posedge clk);
    ridx = 0;
    rec  = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!c_done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, int'(k < 300), 1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    reset = 1'b0; start = 1'b0; num_q = '0; ofifo_full = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cen",  int'(mem_cen),  1);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_inst", int'(inst),     0);
    check("rst_busy", int'(busy),     0);
    check("rst_done", int'(done),     0);
    reset = 1'b1;
    @(negedge clk);

    // Basic run
    do_start(4);
    wait_done("basic");
    analyze();
    check("basic_busy0", int'(t_busy[0]), 1);
    check("basic_nrd", n_rd, 14);
    check_addrs("basic_key", 0, 10, 0);
    check_addrs("basic_qry", 10, 4, 16);
    errs = 0;
    for (int r = 1; r <= 16; r++)
      if (t_inst[r] != ((r <= 10) ? 2'b01 : ((r == 11 || r == 16) ? 2'b00 : 2'b10))) errs++;
    check("basic_inst_seq", errs, 0);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_idx", done_idx, 24);
    check("basic_busy_after", int'(t_busy[done_idx + 1]), 0);
    repeat (10) @(negedge clk);

    // Zero queries
    do_start(0);
    wait_done("zero");
    analyze();
    check("zero_nrd", n_rd, 10);
    check("zero_nq10", n_q10, 0);
    check("zero_done_idx", done_idx, 12);
    repeat (4) @(negedge clk);

    // Backpressure
    do_start(6);
    repeat (12) @(negedge clk);
    ofifo_full = 1'b1;
    repeat (3) @(negedge clk);
    ofifo_full = 1'b0;
    wait_done("bp");
    analyze();
    check("bp_nrd", n_rd, 16);
    check_addrs("bp_qry", 10, 6, 16);
    check("bp_nq10", n_q10, 6);
    check("bp_bubbles", bubbles, 3);
    check("bp_done_idx", done_idx, 29);
    repeat (4) @(negedge clk);

    // Start collisions during LOAD and DRAIN carry a different num_q
    do_start(4);
    repeat (3) @(negedge clk);
    start = 1'b1; num_q = 6'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("coll");
    analyze();
    check("coll_nrd", n_rd, 14);
    check_addrs("coll_key", 0, 10, 0);
    check_addrs("coll_qry", 10, 4, 16);
    check("coll_done_cnt", done_cnt, 1);
    check("coll_done_idx", done_idx, 24);
    do_start(2);
    check("restart_busy", int'(busy), 1);
    check("restart_cen", int'(mem_cen), 0);
    check("restart_addr", int'(mem_addr), 0);
    wait_done("restart");
    analyze();
    check("restart_nrd", n_rd, 12);
    check("restart_done_cnt", done_cnt, 1);
    repeat (4) @(negedge clk);

    // Reset on the second query read
    do_start(4);
    repeat (12) @(negedge clk);
    check("rmx_pre_cen", int'(mem_cen), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rmx_cen",  int'(mem_cen),  1);
    check("rmx_addr", int'(mem_addr), 0);
    check("rmx_inst", int'(inst),     0);
    check("rmx_busy", int'(busy),     0);
    check("rmx_done", int'(done),     0);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    do_start(2);
    wait_done("rmx_rerun");
    analyze();
    check("rmx_nrd", n_rd, 12);
    check_addrs("rmx_key", 0, 10, 0);
    check_addrs("rmx_qry", 10, 2, 16);
    check("rmx_done_cnt", done_cnt, 1);
    repeat (4) @(negedge clk);

    // Address wrap with early writes; IDLE writes must be ignored
    sel_wrap = 1'b1;
    wr_mode  = 1'b1;
    man_wr   = 1'b1;
    repeat (3) @(negedge clk);
    man_wr = 1'b0;
    @(negedge clk);
    do_start(4);
    repeat (2) @(negedge clk);
    man_wr = 1'b1;
    repeat (4) @(negedge clk);
    man_wr = 1'b0;
    wait_done("wrap");
    analyze();
    check("wrap_nrd", n_rd, 14);
    check_addrs("wrap_qry", 10, 4, 126);
    check("wrap_done_cnt", done_cnt, 1);
    check("wrap_done_idx", done_idx, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
